multicycle_main_fsm: RTL and testbench
======================================

# multicycle_main_fsm

Main control state machine for the multicycle RV32I core. It sits upstream of the ALU decoder and produces the 2-bit ALUOp class that the decoder expands into the 3-bit ALU control code. It also produces every datapath mux select and write strobe, sequencing lw, sw, R-type, I-type ALU, beq and jal through fetch/decode/execute/memory/writeback states. It waits on a single-port memory ready handshake.

## Interface
- Parameters: none. State encoding is fixed; see Operation.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- op  in  7  opcode field of the instruction register (instr[6:0])
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory has completed the current access this cycle
- pc_write  out  1  PC register enable
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_write  out  1  memory write request
- ir_write  out  1  instruction/OldPC register enable
- result_src  out  2  result mux select: 00 ALUOut, 01 Data, 10 ALUResult
- alu_src_a  out  2  SrcA mux select: 00 PC, 01 OldPC, 10 RD1
- alu_src_b  out  2  SrcB mux select: 00 RD2, 01 ImmExt, 10 constant 4
- alu_op  out  2  to ALU decoder: 00 add, 01 subtract, 10 decode by funct
- reg_write  out  1  register file write enable
- state  out  4  current state, for debug/trace
- illegal  out  1  one-cycle pulse on an unsupported opcode

## Operation
- States: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10, ILLEGAL=11. Codes 12–15 are unreachable and recover to FETCH.
- Moore outputs by state. Unlisted outputs are 0.
  - FETCH: adr_src 0, alu_src_a 00, alu_src_b 10, alu_op 00, result_src 10. ir_write = mem_ready. Internal pc_update = mem_ready.
  - DECODE: alu_src_a 01, alu_src_b 01, alu_op 00. Computes the branch/jump target into ALUOut.
  - MEMADR: alu_src_a 10, alu_src_b 01, alu_op 00.
  - MEMREAD: adr_src 1.
  - MEMWB: result_src 01, reg_write 1.
  - MEMWRITE: adr_src 1, mem_write 1. mem_write is held until the mem_ready cycle.
  - EXECUTER: alu_src_a 10, alu_src_b 00, alu_op 10.
  - EXECUTEI: alu_src_a 10, alu_src_b 01, alu_op 10.
  - ALUWB: result_src 00, reg_write 1.
  - BEQ: alu_src_a 10, alu_src_b 00, alu_op 01, result_src 00. Internal branch = 1.
  - JAL: alu_src_a 01, alu_src_b 10, alu_op 00, result_src 00. Internal pc_update = 1.
  - ILLEGAL: illegal = 1.
- pc_write = pc_update | (branch & zero).
- Transitions:
  - FETCH → DECODE when mem_ready; otherwise stay in FETCH.
  - DECODE by op:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECUTER
    - 0010011 → EXECUTEI
    - 1100011 → BEQ
    - 1101111 → JAL
    - any other value → ILLEGAL
  - MEMADR → MEMREAD if op[5] = 0, MEMWRITE if op[5] = 1.
  - MEMREAD → MEMWB when mem_ready; otherwise stay.
  - MEMWRITE → FETCH when mem_ready; otherwise stay.
  - EXECUTER → ALUWB; EXECUTEI → ALUWB; JAL → ALUWB.
  - MEMWB → FETCH; ALUWB → FETCH; BEQ → FETCH; ILLEGAL → FETCH.
- op is sampled only in DECODE and MEMADR. The instruction register holds op stable after FETCH.

## Timing
- The state register updates on the rising edge of clk. All outputs are combinational from state plus mem_ready and zero, with no extra latency.
- Reset:
  - rst = 1 at an edge → state = FETCH on that edge, regardless of the current state. This includes mid-access states such as MEMWRITE waiting on mem_ready.
  - While rst = 1, pc_write, ir_write, mem_write, reg_write and illegal are forced to 0.
  - Selects during reset show FETCH values: adr_src 0, alu_src_a 00, alu_src_b 10, alu_op 00, result_src 10; state = 0.
- Cycle counts with mem_ready tied to 1:
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type and I-type: 4 cycles
  - jal: 4 cycles
  - beq: 3 cycles
  - illegal opcode: 3 cycles
- Each mem_ready = 0 cycle in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- The write strobes and the ir/pc enables are single-cycle per instruction:
  - reg_write: once per writeback.
  - ir_write: in the FETCH ready cycle only.
  - pc_write from pc_update: in the FETCH ready cycle, and in JAL for jal.
  - pc_write from branch: in BEQ only when zero = 1.
  - mem_write is the exception: it stays high through every MEMWRITE cycle until mem_ready.

## Test plan
- Reset: hold rst for 2 cycles from MEMWRITE with mem_ready = 0 → state = 0 and all strobes 0 during reset; the first post-reset cycle shows FETCH selects.
- lw, mem_ready = 1: state sequence 0,1,2,3,4,0. reg_write = 1 only in state 4 with result_src = 01. alu_op reads 00 in states 0,1,2.
- sw with mem_ready low for 3 cycles in MEMWRITE → mem_write high for 4 consecutive cycles, then state = 0. reg_write is never asserted.
- R-type (op 0110011) then addi (op 0010011) → alu_op = 10 in states 6 and 7 respectively. ALUWB follows each; total 8 cycles.
- beq run twice, once with zero = 1 and once with zero = 0 → pc_write asserted in BEQ (alu_op = 01) only for the zero = 1 run. Both runs return to FETCH.
- jal gives pc_write in both FETCH and JAL, then reg_write in ALUWB. op = 0110111 gives illegal = 1 for exactly one cycle (state 11), then FETCH.

Source files
------------

// File: rtl/multicycle_main_fsm.sv
// multicycle_main_fsm: main control FSM of the multicycle RV32I core; drives datapath selects,
// write strobes and the ALUOp class, stalling on the single-port memory ready handshake.
module multicycle_main_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic [3:0] state,
  output logic       illegal
);
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;
  state_t r_state, w_next, w_cur;
  logic w_pc_update, w_branch, w_ir, w_mw, w_rw, w_ill;
  // Reset presents FETCH selects immediately, even before the reset edge lands.
  assign w_cur = rst ? S_FETCH : r_state;
  always_ff @(posedge clk) r_state <= rst ? S_FETCH : w_next;
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:
        case (op)
          7'b0000011, 7'b0100011: w_next = S_MEMADR;
          7'b0110011:             w_next = S_EXECUTER;
          7'b0010011:             w_next = S_EXECUTEI;
          7'b1100011:             w_next = S_BEQ;
          7'b1101111:             w_next = S_JAL;
          default:                w_next = S_ILLEGAL;
        endcase
      S_MEMADR:   w_next = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  w_next = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: w_next = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTER, S_EXECUTEI, S_JAL: w_next = S_ALUWB;
      default:    w_next = S_FETCH;
    endcase
  end
  always_comb begin
    adr_src     = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    w_pc_update = 1'b0;
    w_branch    = 1'b0;
    w_ir        = 1'b0;
    w_mw        = 1'b0;
    w_rw        = 1'b0;
    w_ill       = 1'b0;
    case (w_cur)
      S_FETCH: begin
        alu_src_b   = 2'b10;
        result_src  = 2'b10;
        w_ir        = mem_ready;
        w_pc_update = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB: begin
        result_src = 2'b01;
        w_rw       = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1;
        w_mw    = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_ALUWB:    w_rw = 1'b1;
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        w_branch  = 1'b1;
      end
      S_JAL: begin
        alu_src_a   = 2'b01;
        alu_src_b   = 2'b10;
        w_pc_update = 1'b1;
      end
      S_ILLEGAL:  w_ill = 1'b1;
      default:    w_ill = 1'b0;
    endcase
  end
  assign pc_write  = ~rst & (w_pc_update | (w_branch & zero));
  assign ir_write  = ~rst & w_ir;
  assign mem_write = ~rst & w_mw;
  assign reg_write = ~rst & w_rw;
  assign illegal   = ~rst & w_ill;
  assign state     = w_cur;
endmodule

// File: tb/tb_multicycle_main_fsm.sv
// tb_multicycle_main_fsm: vector table plus random instruction stream checked against a
// route-per-opcode reference model.
module tb_multicycle_main_fsm;
  logic       clk = 1'b0;
  logic       rst, zero, mem_ready;
  logic [6:0] op;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [3:0] state;
  int n_checks = 0, n_fail = 0;

  multicycle_main_fsm dut (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .state(state), .illegal(illegal)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011;
  localparam logic [6:0] BQ = 7'b1100011, JL = 7'b1101111, BAD = 7'b0110111;
  // {state, pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b, alu_op, reg_write, illegal}
  localparam logic [17:0] E_F1   = 18'b0000_1001_10_00_10_00_0_0;
  localparam logic [17:0] E_F0   = 18'b0000_0000_10_00_10_00_0_0;
  localparam logic [17:0] E_DEC  = 18'b0001_0000_00_01_01_00_0_0;
  localparam logic [17:0] E_MA   = 18'b0010_0000_00_10_01_00_0_0;
  localparam logic [17:0] E_MR   = 18'b0011_0100_00_00_00_00_0_0;
  localparam logic [17:0] E_MWB  = 18'b0100_0000_01_00_00_00_1_0;
  localparam logic [17:0] E_MW   = 18'b0101_0110_00_00_00_00_0_0;
  localparam logic [17:0] E_EXR  = 18'b0110_0000_00_10_00_10_0_0;
  localparam logic [17:0] E_EXI  = 18'b0111_0000_00_10_01_10_0_0;
  localparam logic [17:0] E_AWB  = 18'b1000_0000_00_00_00_00_1_0;
  localparam logic [17:0] E_BQ1  = 18'b1001_1000_00_10_00_01_0_0;
  localparam logic [17:0] E_BQ0  = 18'b1001_0000_00_10_00_01_0_0;
  localparam logic [17:0] E_JAL  = 18'b1010_1000_00_01_10_00_0_0;
  localparam logic [17:0] E_ILL  = 18'b1011_0000_00_00_00_00_0_1;

  typedef struct {
    logic rst; logic [6:0] op; logic zero; logic mr; logic [17:0] exp;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic r, input logic [6:0] o, input logic z, input logic m, input logic [17:0] e);
    vec_t v;
    v.rst = r; v.op = o; v.zero = z; v.mr = m; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic check(input string tag, input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s.%s got %0d expected %0d (t=%0t)", tag, nm, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [17:0] e);
    check(tag, "state",      int'(state),      int'(e[17:14]));
    check(tag, "pc_write",   int'(pc_write),   int'(e[13]));
    check(tag, "adr_src",    int'(adr_src),    int'(e[12]));
    check(tag, "mem_write",  int'(mem_write),  int'(e[11]));
    check(tag, "ir_write",   int'(ir_write),   int'(e[10]));
    check(tag, "result_src", int'(result_src), int'(e[9:8]));
    check(tag, "alu_src_a",  int'(alu_src_a),  int'(e[7:6]));
    check(tag, "alu_src_b",  int'(alu_src_b),  int'(e[5:4]));
    check(tag, "alu_op",     int'(alu_op),     int'(e[3:2]));
    check(tag, "reg_write",  int'(reg_write),  int'(e[1]));
    check(tag, "illegal",    int'(illegal),    int'(e[0]));
  endtask

  // Reference model: each opcode maps to the list of states its instruction walks through.
  int route[$];
  int idx = 0;

  task automatic set_route(input logic [6:0] o);
    case (o)
      LW:      route = '{0, 1, 2, 3, 4};
      SW:      route = '{0, 1, 2, 5};
      RT:      route = '{0, 1, 6, 8};
      IT:      route = '{0, 1, 7, 8};
      BQ:      route = '{0, 1, 9};
      JL:      route = '{0, 1, 10, 8};
      default: route = '{0, 1, 11};
    endcase
  endtask

  function automatic logic [17:0] model_out(input int s, input logic m, input logic z);
    case (s)
      0:       return m ? E_F1 : E_F0;
      1:       return E_DEC;
      2:       return E_MA;
      3:       return E_MR;
      4:       return E_MWB;
      5:       return E_MW;
      6:       return E_EXR;
      7:       return E_EXI;
      8:       return E_AWB;
      9:       return z ? E_BQ1 : E_BQ0;
      10:      return E_JAL;
      default: return E_ILL;
    endcase
  endfunction

  function automatic logic [6:0] pick_op();
    logic [6:0] legal[6];
    legal = '{LW, SW, RT, IT, BQ, JL};
    return ($urandom_range(0, 9) < 7) ? legal[$urandom_range(0, 5)] : 7'($urandom);
  endfunction

  initial begin
    logic r, m, z;
    int s;
    add(0, LW, 0, 1, E_F1); add(0, LW, 0, 1, E_DEC); add(0, LW, 0, 1, E_MA);
    add(0, LW, 0, 0, E_MR); add(0, LW, 0, 1, E_MR);  add(0, LW, 0, 1, E_MWB);
    add(0, SW, 0, 1, E_F1); add(0, SW, 0, 1, E_DEC); add(0, SW, 0, 1, E_MA);
    add(0, SW, 0, 0, E_MW); add(0, SW, 0, 0, E_MW);  add(0, SW, 0, 0, E_MW); add(0, SW, 0, 1, E_MW);
    add(0, RT, 0, 1, E_F1); add(0, RT, 0, 1, E_DEC); add(0, RT, 0, 1, E_EXR); add(0, RT, 0, 1, E_AWB);
    add(0, IT, 0, 1, E_F1); add(0, IT, 0, 1, E_DEC); add(0, IT, 0, 1, E_EXI); add(0, IT, 0, 1, E_AWB);
    add(0, BQ, 0, 1, E_F1); add(0, BQ, 0, 1, E_DEC); add(0, BQ, 1, 1, E_BQ1);
    add(0, BQ, 1, 1, E_F1); add(0, BQ, 1, 1, E_DEC); add(0, BQ, 0, 1, E_BQ0);
    add(0, JL, 0, 1, E_F1); add(0, JL, 0, 1, E_DEC); add(0, JL, 0, 1, E_JAL); add(0, JL, 0, 1, E_AWB);
    add(0, BAD, 0, 0, E_F0); add(0, BAD, 0, 1, E_F1); add(0, BAD, 0, 1, E_DEC); add(0, BAD, 0, 1, E_ILL);
    add(0, SW, 0, 1, E_F1); add(0, SW, 0, 1, E_DEC); add(0, SW, 0, 1, E_MA); add(0, SW, 0, 0, E_MW);
    add(1, SW, 0, 0, E_F0); add(1, SW, 0, 1, E_F0);  add(0, SW, 0, 0, E_F0);

    rst = 1'b1; op = 7'd0; zero = 1'b0; mem_ready = 1'b1;
    #1 check_all("reset0", E_F0);
    @(posedge clk); #2 check_all("reset1", E_F0);
    @(posedge clk);
    foreach (tbl[i]) begin
      #1 rst = tbl[i].rst; op = tbl[i].op; zero = tbl[i].zero; mem_ready = tbl[i].mr;
      #1 check_all($sformatf("vec%0d", i), tbl[i].exp);
      @(posedge clk);
    end
    // Last vector left the FSM in FETCH with mem_ready low, so the model starts at a route head.
    idx = 0;
    for (int c = 0; c < 3000; c++) begin
      #1 r = ($urandom_range(0, 99) < 3);
      m = ($urandom_range(0, 99) < 70);
      z = 1'($urandom_range(0, 1));
      if (idx == 0) begin
        op = pick_op();
        set_route(op);
      end
      rst = r; mem_ready = m; zero = z;
      #1 check_all("rand", r ? E_F0 : model_out(route[idx], m, z));
      s = route[idx];
      if (r) idx = 0;
      else if (!((s == 0 || s == 3 || s == 5) && !m)) idx = (idx + 1 == route.size()) ? 0 : idx + 1;
      @(posedge clk);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
